serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder that computes one bit per clock through a single instance of the team's existing full_adder cell.
- Loads two parallel operands on a start handshake and shifts them out LSB-first. A carry flip-flop closes the loop between bits.
- Returns a parallel sum and carry-out with a one-cycle done pulse.
- Sits in area-constrained datapaths as the sequential wrapper around full_adder; it feeds the cell each bit and consumes its s and c outputs.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on the accepted start.
- b  input  WIDTH  operand B; captured on the accepted start.
- cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when sum and cout become valid.
- sum  output  WIDTH  result; a shift register internally.
- cout  output  1  final carry.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry flip-flop and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum<=0, state<=RUN.
- IDLE with start=0: hold state; sum and cout keep their last values.
- RUN, each cycle:
  - The full_adder sees x=a_sh[0], y=b_sh[0], z=carry.
  - sum<={s, sum[WIDTH-1:1]}.
  - carry<=c.
  - a_sh and b_sh shift right by one, zero-filled.
  - cnt<=cnt+1.
- RUN exit: when cnt==WIDTH-1, that final bit is processed, then cout<=c, done<=1, state<=DONE.
- DONE: lasts exactly one cycle. With start=0 it returns to IDLE; with start=1 a new operation is accepted (back-to-back).
- Latency: done is high in the cycle after the WIDTH-th rising edge following the start-sampling edge. Throughput is one result per WIDTH+1 cycles.
- busy=1 exactly during the WIDTH RUN cycles.
- start while in RUN: ignored; no effect on operands or result.
- a, b and cin changing after acceptance: no effect.
- Validity of sum: contents during RUN are partial and undefined for consumers. sum and cout are valid from done until the next accepted start.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Reset mid-RUN: the operation is aborted, outputs go to their reset values, and no done pulse is produced.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on the accepted start alongside a and b.
  - sub=1 loads b_sh<=~b and carry<=1, ignoring cin, so the result is a - b in two's complement.
  - cout=1 means no borrow.
  - sub=0 behaves identically to the base block.
- Undefined: port absent; add-only.

Decomposition:
- Package serial_adder_pkg holds:
  - state enum type (IDLE, RUN, DONE);
  - localparam function for CNT_W.
- The one natural sub-module is the existing full_adder cell, instantiated once. The FSM, shift registers and counter stay in serial_adder itself.

Test Plan:
- Add with WIDTH=8: a=0x5A, b=0x33, cin=0, start for 1 cycle -> busy high for 8 cycles; done pulses on the cycle after the 8th edge; sum=0x8D, cout=0.
- Wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start during RUN: start a=0x01, b=0x01; pulse start with a=0x80, b=0x80 at RUN cycle 3 -> sum=0x02, cout=0; exactly one done pulse.
- Back-to-back: hold start=1 continuously with a=0x10, b=0x20, then a=0x0F, b=0x01 -> done pulses 9 cycles apart; results 0x30, then 0x10; busy low only in the DONE cycles.
- Reset mid-op: drop rst_n asynchronously at RUN cycle 5 -> immediately sum=0, cout=0, busy=0, done=0; no done pulse afterwards; the next start runs normally.
- With SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1. sub=1, a=0x00, b=0x01 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Pulled in by serial_adder; the FSM state encoding lives here.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold 0..WIDTH-1 with headroom for the terminal compare.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell: s = x ^ y ^ z, c = majority(x, y, z).
module full_adder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s,
    output logic c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around one full_adder cell, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port for a - b.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold last result
// RUN   | one operand bit per cycle through full_adder
// DONE  | one-cycle result-valid pulse; start here is accepted back-to-back
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

    full_adder u_full_adder (
        .x (a_sh_q[0]),
        .y (b_sh_q[0]),
        .z (carry_q),
        .s (fa_s),
        .c (fa_c)
    );

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: invert b and force the carry-in.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
